// File: rtl/state_serializer.sv
// rtl/state_serializer.sv - captures a 16-byte state block and emits it one byte per handshake
module state_serializer #(
    parameter int NUM_BYTES = 16,
    parameter int BYTE_W    = 8,
    localparam int IDX_W    = $clog2(NUM_BYTES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic [NUM_BYTES*BYTE_W-1:0] state_in,
    input  logic                        out_ready,
    output logic [BYTE_W-1:0]           out_byte,
    output logic [IDX_W-1:0]            out_addr,
    output logic                        out_valid,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [BYTE_W-1:0] buf_mem [NUM_BYTES];
    logic [IDX_W-1:0]  idx;
    logic              xfer;
    logic              last;

    assign xfer = (state == SEND) && out_ready;
    assign last = (idx == IDX_W'(NUM_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready && last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Byte 0 sits in the most significant lane of state_in.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
            for (int k = 0; k < NUM_BYTES; k++) begin
                buf_mem[k] <= '0;
            end
        end else if (state == IDLE && load) begin
            idx <= '0;
            for (int k = 0; k < NUM_BYTES; k++) begin
                buf_mem[k] <= state_in[(NUM_BYTES-1-k)*BYTE_W +: BYTE_W];
            end
        end else if (xfer && !last) begin
            idx <= idx + 1'b1;
        end
    end

    // Index and buffer only change on capture or transfer, so both outputs hold in IDLE.
    assign out_addr = idx;
    assign out_byte = buf_mem[idx];

endmodule

// File: tb/tb_state_serializer.sv
// tb/tb_state_serializer.sv - self-checking bench for state_serializer
module tb_state_serializer;

    logic         clk;
    logic         rst;
    logic         load;
    logic [127:0] state_in;
    logic         out_ready;
    logic [7:0]   out_byte;
    logic [3:0]   out_addr;
    logic         out_valid;
    logic         busy;
    logic         done;

    int tests = 0;
    int fails = 0;

    localparam logic [127:0] BLK_V = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] BLK_W = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] BLK_F = {128{1'b1}};

    state_serializer #(.NUM_BYTES(16), .BYTE_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .state_in  (state_in),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_addr  (out_addr),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         load;
        logic         ready;
        logic [127:0] din;
        logic         valid;
        logic [3:0]   addr;
        logic [7:0]   data;
        logic         busy;
        logic         done;
    } vec_t;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } ent_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic r, input logic l, input logic rdy, input logic [127:0] din);
        rst       = r;
        load      = l;
        out_ready = rdy;
        state_in  = din;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [3:0] a,
                              input logic [7:0] d, input logic b, input logic dn,
                              input bit check_data);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".busy"},  32'(busy),      32'(b));
        check({tag, ".done"},  32'(done),      32'(dn));
        if (check_data) begin
            check({tag, ".addr"}, 32'(out_addr), 32'(a));
            check({tag, ".byte"}, 32'(out_byte), 32'(d));
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [127:0] blk, input int k);
        return blk[127-8*k -: 8];
    endfunction

    ent_t       mq [$];
    logic       m_done_due;
    logic [3:0] m_last_a;
    logic [7:0] m_last_d;

    initial begin
        apply(1'b1, 1'b0, 1'b0, '0);

        // rst load ready din | valid addr byte busy done
        tbl[0]  = '{1'b1, 1'b0, 1'b0, BLK_V, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, BLK_V, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, BLK_V, 1'b1, 4'd0, 8'h00, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, BLK_F, 1'b1, 4'd0, 8'h00, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, BLK_F, 1'b1, 4'd1, 8'h11, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, BLK_F, 1'b1, 4'd2, 8'h22, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, BLK_F, 1'b1, 4'd2, 8'h22, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, BLK_F, 1'b1, 4'd3, 8'h33, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, BLK_F, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, BLK_W, 1'b1, 4'd0, 8'h0F, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, BLK_V, 1'b1, 4'd0, 8'h0F, 1'b1, 1'b0};

        for (int i = 0; i < 11; i++) begin
            apply(tbl[i].rst, tbl[i].load, tbl[i].ready, tbl[i].din);
            step();
            expect_out($sformatf("tbl[%0d]", i), tbl[i].valid, tbl[i].addr, tbl[i].data,
                       tbl[i].busy, tbl[i].done, 1'b1);
        end

        // Full-rate stream of the reference block
        apply(1'b1, 1'b0, 1'b0, '0);
        step();
        apply(1'b0, 1'b1, 1'b1, BLK_V);
        step();
        expect_out("stream.first", 1'b1, 4'd0, 8'h00, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k < 16; k++) begin
            apply(1'b0, 1'b0, 1'b1, BLK_V);
            step();
            expect_out($sformatf("stream.b%0d", k), 1'b1, 4'(k), byte_of(BLK_V, k), 1'b1, 1'b0, 1'b1);
        end
        apply(1'b0, 1'b0, 1'b1, BLK_V);
        step();
        expect_out("stream.done", 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0);
        // Load during DONE must be ignored
        apply(1'b0, 1'b1, 1'b1, BLK_W);
        step();
        expect_out("stream.idle", 1'b0, 4'd15, 8'hFF, 1'b0, 1'b0, 1'b1);

        // Back-to-back: load in the first IDLE cycle, 18-cycle period
        apply(1'b0, 1'b1, 1'b1, BLK_W);
        step();
        expect_out("b2b.first", 1'b1, 4'd0, 8'h0F, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k < 16; k++) begin
            apply(1'b0, 1'b0, 1'b1, BLK_V);
            step();
            expect_out($sformatf("b2b.b%0d", k), 1'b1, 4'(k), byte_of(BLK_W, k), 1'b1, 1'b0, 1'b1);
        end
        apply(1'b0, 1'b0, 1'b1, BLK_V);
        step();
        expect_out("b2b.done", 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b1, BLK_V);
        step();

        // Reset right after the addr-5 transfer
        apply(1'b0, 1'b1, 1'b1, BLK_V);
        step();
        for (int k = 1; k <= 6; k++) begin
            apply(1'b0, 1'b0, 1'b1, BLK_V);
            step();
        end
        check("rst_mid.pre_addr", 32'(out_addr), 32'd6);
        apply(1'b1, 1'b0, 1'b1, BLK_V);
        step();
        expect_out("rst_mid.after", 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 20; k++) begin
            apply(1'b0, 1'b0, 1'b1, BLK_V);
            step();
            check("rst_mid.no_done", 32'(done), 32'd0);
            check("rst_mid.no_valid", 32'(out_valid), 32'd0);
        end
        apply(1'b0, 1'b1, 1'b1, BLK_V);
        step();
        expect_out("rst_mid.restart", 1'b1, 4'd0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Randomized traffic against a queue-based reference model
        apply(1'b1, 1'b0, 1'b0, '0);
        step();
        mq.delete();
        m_done_due = 1'b0;
        m_last_a   = '0;
        m_last_d   = '0;
        for (int c = 0; c < 2000; c++) begin
            logic         r;
            logic         l;
            logic         rdy;
            logic [127:0] din;
            r   = ($urandom_range(0, 79) == 0);
            l   = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            din = {$urandom, $urandom, $urandom, $urandom};
            apply(r, l, rdy, din);
            if (r) begin
                mq.delete();
                m_done_due = 1'b0;
                m_last_a   = '0;
                m_last_d   = '0;
            end else if (mq.size() > 0) begin
                if (rdy) begin
                    void'(mq.pop_front());
                    if (mq.size() == 0) m_done_due = 1'b1;
                end
            end else if (m_done_due) begin
                m_done_due = 1'b0;
            end else if (l) begin
                for (int k = 0; k < 16; k++) mq.push_back({4'(k), byte_of(din, k)});
            end
            if (mq.size() > 0) begin
                m_last_a = mq[0].a;
                m_last_d = mq[0].d;
            end
            step();
            expect_out($sformatf("rand[%0d]", c), mq.size() > 0, m_last_a, m_last_d,
                       (mq.size() > 0) || m_done_due, m_done_due, (mq.size() > 0) || !m_done_due);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
